// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the 65C02 interrupt controller: register offsets and
// the register-select type used by the bus decode.
package irq_ctl_pkg;

`include "irq_defs.vh"

    typedef enum logic [1:0] {
        REG_STATUS = OFS_STATUS,
        REG_ENABLE = OFS_ENABLE,
        REG_EDGE   = OFS_EDGE,
        REG_VECTOR = OFS_VECTOR
    } reg_sel_e;

endpackage

// File: rtl/irq_ctl_sync_edge.sv
// Two-flop synchroniser followed by a previous-level flop for rising-edge detection.
// The previous-level flop keeps its reset value until the chain holds real samples.
module sync_edge #(
    parameter logic RST_PREV = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise
);

    logic       r_s1;
    logic       r_s2;
    logic       r_prev;
    logic [1:0] r_fill;

    // Synchroniser chain; r_fill masks the zeroed stages so a line held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= RST_PREV;
            r_fill <= 2'b00;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_fill <= {r_fill[0], 1'b1};
            r_prev <= r_fill[1] ? r_s2 : RST_PREV;
        end
    end

    assign o_lvl  = r_s2;
    assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/irq_defs.vh
// Register window offsets and the "no active source" vector value.
// Shared by the interrupt controller, the bus decoder and the test bench.
localparam logic [1:0] OFS_STATUS = 2'd0;
localparam logic [1:0] OFS_ENABLE = 2'd1;
localparam logic [1:0] OFS_EDGE   = 2'd2;
localparam logic [1:0] OFS_VECTOR = 2'd3;
localparam logic [7:0] VEC_NONE   = 8'h80;

// File: rtl/irq_ctl.sv
// Interrupt controller in front of the 65C02: synchronised sources, STATUS/ENABLE/EDGE/VECTOR
// register window, and an NMI latch acknowledged by the core's own vector fetch.
module irq_ctl
    import irq_ctl_pkg::*;
#(
    parameter int          NSRC    = 8,
    parameter logic [15:0] BASE    = 16'hFE00,
    parameter logic [15:0] NMI_VEC = 16'hFFFA
) (
    input  logic            clk,
    input  logic            RST_N,
    input  logic [NSRC-1:0] SRC,
    input  logic            NMI_IN,
    input  logic [15:0]     AD,
    input  logic [7:0]      DO,
    input  logic            WE,
    input  logic            RDY,
    output logic [7:0]      DAT,
    output logic            SEL,
    output logic            IRQ,
    output logic            NMI
);

    // Highest pending-and-enabled index wins; bit NSRC-1 has top priority.
    function automatic logic [7:0] prio_vec(input logic [NSRC-1:0] act);
        logic [7:0] v;
        v = VEC_NONE;
        for (int i = 0; i < NSRC; i++) begin
            if (act[i]) v = {5'b00000, 3'(i)};
        end
        return v;
    endfunction

    logic [NSRC-1:0] w_src_lvl;
    logic [NSRC-1:0] w_src_rise;
    logic            w_nmi_lvl;
    logic            w_nmi_rise;
    logic            w_nmi_set;

    logic            w_hit;
    logic            w_wr;
    logic            w_rd;
    logic            w_ack;
    reg_sel_e        w_ofs;

    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_en_nxt;
    logic [NSRC-1:0] w_edge_nxt;
    logic [NSRC-1:0] w_pend_nxt;
    logic [7:0]      w_pend8;
    logic [7:0]      w_en8;
    logic [7:0]      w_edge8;
    logic [7:0]      w_vec;
    logic [7:0]      w_rdata;

    logic [NSRC-1:0] r_en;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_pend;
    logic            r_irq;
    logic            r_nmi;
    logic [7:0]      r_dat;
    logic            r_sel;

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src_sync
            sync_edge #(.RST_PREV(1'b0)) u_sync (
                .clk    (clk),
                .rst_n  (RST_N),
                .i_d    (SRC[g]),
                .o_lvl  (w_src_lvl[g]),
                .o_rise (w_src_rise[g])
            );
        end
    endgenerate

    sync_edge #(.RST_PREV(1'b1)) u_nmi_sync (
        .clk    (clk),
        .rst_n  (RST_N),
        .i_d    (NMI_IN),
        .o_lvl  (w_nmi_lvl),
        .o_rise (w_nmi_rise)
    );

    assign w_nmi_set = w_nmi_rise & w_nmi_lvl;

    assign w_hit = (AD[15:2] == BASE[15:2]);
    assign w_ofs = reg_sel_e'(AD[1:0]);
    assign w_wr  = w_hit & WE & RDY;
    assign w_rd  = w_hit & ~WE;
    assign w_ack = (AD == NMI_VEC) & ~WE & RDY;

    assign w_clr      = (w_wr && (w_ofs == REG_STATUS)) ? DO[NSRC-1:0] : {NSRC{1'b0}};
    assign w_en_nxt   = (w_wr && (w_ofs == REG_ENABLE)) ? DO[NSRC-1:0] : r_en;
    assign w_edge_nxt = (w_wr && (w_ofs == REG_EDGE))   ? DO[NSRC-1:0] : r_edge;

    // Pending next state: an EDGE write clears, latched set beats STATUS clear, level bits follow sync.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NSRC; i++) begin
            if (w_wr && (w_ofs == REG_EDGE)) begin
                w_pend_nxt[i] = 1'b0;
            end else if (r_edge[i]) begin
                if (w_src_rise[i]) begin
                    w_pend_nxt[i] = 1'b1;
                end else if (w_clr[i]) begin
                    w_pend_nxt[i] = 1'b0;
                end else begin
                    w_pend_nxt[i] = r_pend[i];
                end
            end else begin
                w_pend_nxt[i] = w_src_lvl[i];
            end
        end
    end

    // Byte-wide views of the registers; bits at and above NSRC read as zero.
    always_comb begin
        w_pend8 = 8'h00;
        w_en8   = 8'h00;
        w_edge8 = 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            w_pend8[i] = r_pend[i];
            w_en8[i]   = r_en[i];
            w_edge8[i] = r_edge[i];
        end
    end

    assign w_vec = prio_vec(r_pend & r_en);

    // Read data reflects register state before this edge's updates.
    always_comb begin
        case (w_ofs)
            REG_STATUS: w_rdata = w_pend8;
            REG_ENABLE: w_rdata = w_en8;
            REG_EDGE:   w_rdata = w_edge8;
            REG_VECTOR: w_rdata = w_vec;
            default:    w_rdata = 8'h00;
        endcase
    end

    // Control/status registers; IRQ is registered from next-state values so it tracks PEND&ENABLE without lag.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_en   <= {NSRC{1'b0}};
            r_edge <= {NSRC{1'b0}};
            r_pend <= {NSRC{1'b0}};
            r_irq  <= 1'b0;
        end else begin
            r_en   <= w_en_nxt;
            r_edge <= w_edge_nxt;
            r_pend <= w_pend_nxt;
            r_irq  <= |(w_pend_nxt & w_en_nxt);
        end
    end

    // NMI latch; a new edge on the acknowledge cycle keeps it set.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_nmi <= 1'b0;
        end else if (w_nmi_set) begin
            r_nmi <= 1'b1;
        end else if (w_ack) begin
            r_nmi <= 1'b0;
        end
    end

    // Synchronous-RAM style read port: nothing moves while RDY is low.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_dat <= 8'h00;
            r_sel <= 1'b0;
        end else if (RDY) begin
            if (w_rd) begin
                r_dat <= w_rdata;
                r_sel <= 1'b1;
            end else begin
                r_sel <= 1'b0;
            end
        end
    end

    assign DAT = r_dat;
    assign SEL = r_sel;
    assign IRQ = r_irq;
    assign NMI = r_nmi;

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: directed literal checks plus a randomized run
// compared every cycle against a sample-history reference model.
module tb_irq_ctl;
    import irq_ctl_pkg::*;

    localparam logic [15:0] BASE = 16'hFE00;
    localparam logic [15:0] NMIV = 16'hFFFA;

    logic        clk;
    logic        RST_N;
    logic [7:0]  SRC;
    logic        NMI_IN;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic        RDY;
    logic [7:0]  DAT;
    logic        SEL;
    logic        IRQ;
    logic        NMI;

    irq_ctl #(.NSRC(8), .BASE(BASE), .NMI_VEC(NMIV)) dut (
        .clk(clk), .RST_N(RST_N), .SRC(SRC), .NMI_IN(NMI_IN), .AD(AD), .DO(DO),
        .WE(WE), .RDY(RDY), .DAT(DAT), .SEL(SEL), .IRQ(IRQ), .NMI(NMI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_en, m_edg, m_pend, m_dat;
    logic       m_sel, m_nmi;
    logic [8:0] smp[$];   // {NMI_IN, SRC} sampled at recent edges since reset, newest last

    function automatic logic [7:0] vec_of(input logic [7:0] act);
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) return 8'(i);
        end
        return VEC_NONE;
    endfunction

    task automatic model_reset();
        m_en = 8'h00; m_edg = 8'h00; m_pend = 8'h00; m_dat = 8'h00;
        m_sel = 1'b0; m_nmi = 1'b0;
        smp.delete();
    endtask

    task automatic model_edge();
        logic [8:0] s2, pv;
        logic [7:0] rise, clr, nxt;
        logic       nrise, hit, wr, ack;
        logic [1:0] ofs;
        int k;
        k  = smp.size();
        s2 = (k >= 2) ? smp[k-2] : 9'h000;
        pv = (k >= 3) ? smp[k-3] : 9'h100;   // NMI history counts as high until real samples arrive
        rise  = s2[7:0] & ~pv[7:0];
        nrise = s2[8] & ~pv[8];
        hit = (AD[15:2] == BASE[15:2]);
        ofs = AD[1:0];
        wr  = hit && WE && RDY;
        if (RDY) begin
            if (hit && !WE) begin
                m_sel = 1'b1;
                case (ofs)
                    OFS_STATUS: m_dat = m_pend;
                    OFS_ENABLE: m_dat = m_en;
                    OFS_EDGE:   m_dat = m_edg;
                    default:    m_dat = vec_of(m_pend & m_en);
                endcase
            end else begin
                m_sel = 1'b0;
            end
        end
        clr = (wr && ofs == OFS_STATUS) ? DO : 8'h00;
        nxt = (m_edg & ((m_pend & ~clr) | rise)) | (~m_edg & s2[7:0]);
        if (wr && ofs == OFS_EDGE) begin
            nxt   = 8'h00;
            m_edg = DO;
        end
        if (wr && ofs == OFS_ENABLE) m_en = DO;
        m_pend = nxt;
        ack   = (AD == NMIV) && !WE && RDY;
        m_nmi = nrise | (m_nmi & ~ack);
        smp.push_back({NMI_IN, SRC});
        if (smp.size() > 3) void'(smp.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge RST_N);
            if (!RST_N) model_reset();
            else model_edge();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_irq", {7'h00, IRQ}, {7'h00, |(m_pend & m_en)});
            chk("cyc_nmi", {7'h00, NMI}, {7'h00, m_nmi});
            chk("cyc_sel", {7'h00, SEL}, {7'h00, m_sel});
            chk("cyc_dat", DAT, m_dat);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic [15:0] a, input logic we, input logic [7:0] d, input logic rdy);
        AD = a; WE = we; DO = d; RDY = rdy;
        @(negedge clk);
        AD = 16'h0000; WE = 1'b0; DO = 8'h00; RDY = 1'b1;
    endtask

    function automatic logic [15:0] reg_addr(input logic [1:0] ofs);
        return BASE + {14'h0000, ofs};
    endfunction

    initial begin
        RST_N = 1'b0; SRC = 8'h00; NMI_IN = 1'b0;
        AD = 16'h0000; DO = 8'h00; WE = 1'b0; RDY = 1'b1;
        step(2);
        chk("rst_irq", {7'h00, IRQ}, 8'h00);
        chk("rst_nmi", {7'h00, NMI}, 8'h00);
        chk("rst_dat", DAT, 8'h00);
        chk("rst_sel", {7'h00, SEL}, 8'h00);
        RST_N = 1'b1;
        step(2);

        // Level mode
        bus(reg_addr(OFS_ENABLE), 1'b1, 8'h01, 1'b1);
        SRC = 8'h01;
        step(2);
        chk("lvl_irq_e2", {7'h00, IRQ}, 8'h00);
        step(1);
        chk("lvl_irq_e3", {7'h00, IRQ}, 8'h01);
        bus(reg_addr(OFS_STATUS), 1'b0, 8'h00, 1'b1);
        chk("lvl_status", DAT, 8'h01);
        chk("lvl_sel", {7'h00, SEL}, 8'h01);
        SRC = 8'h00;
        step(2);
        chk("lvl_fall_e2", {7'h00, IRQ}, 8'h01);
        step(1);
        chk("lvl_fall_e3", {7'h00, IRQ}, 8'h00);

        // Edge latch
        bus(reg_addr(OFS_EDGE), 1'b1, 8'h04, 1'b1);
        bus(reg_addr(OFS_ENABLE), 1'b1, 8'h04, 1'b1);
        SRC = 8'h04;
        step(1);
        SRC = 8'h00;
        step(6);
        chk("edge_irq_hold", {7'h00, IRQ}, 8'h01);
        bus(reg_addr(OFS_VECTOR), 1'b0, 8'h00, 1'b1);
        chk("edge_vector", DAT, 8'h02);
        bus(reg_addr(OFS_STATUS), 1'b1, 8'h04, 1'b1);
        chk("edge_clr_irq", {7'h00, IRQ}, 8'h00);

        // Set/clear race: the clear lands on the same edge as the synchronised rise
        SRC = 8'h04;
        step(2);
        bus(reg_addr(OFS_STATUS), 1'b1, 8'h04, 1'b1);
        bus(reg_addr(OFS_STATUS), 1'b0, 8'h00, 1'b1);
        chk("race_pend", DAT, 8'h04);
        chk("race_irq", {7'h00, IRQ}, 8'h01);
        SRC = 8'h00;
        bus(reg_addr(OFS_STATUS), 1'b1, 8'h04, 1'b1);
        chk("race_clr_irq", {7'h00, IRQ}, 8'h00);

        // Priority
        SRC = 8'h81;
        bus(reg_addr(OFS_EDGE), 1'b1, 8'h00, 1'b1);
        bus(reg_addr(OFS_ENABLE), 1'b1, 8'hFF, 1'b1);
        step(1);
        bus(reg_addr(OFS_VECTOR), 1'b0, 8'h00, 1'b1);
        chk("prio_vec7", DAT, 8'h07);
        bus(reg_addr(OFS_ENABLE), 1'b1, 8'h01, 1'b1);
        bus(reg_addr(OFS_VECTOR), 1'b0, 8'h00, 1'b1);
        chk("prio_vec0", DAT, 8'h00);
        bus(reg_addr(OFS_ENABLE), 1'b1, 8'h00, 1'b1);
        chk("prio_irq_off", {7'h00, IRQ}, 8'h00);
        bus(reg_addr(OFS_VECTOR), 1'b0, 8'h00, 1'b1);
        chk("prio_vec_none", DAT, 8'h80);

        // RDY=0 read leaves SEL/DAT alone
        bus(reg_addr(OFS_STATUS), 1'b0, 8'h00, 1'b1);
        chk("rdy_status", DAT, 8'h81);
        bus(reg_addr(OFS_ENABLE), 1'b0, 8'h00, 1'b0);
        chk("rdy0_dat", DAT, 8'h81);
        chk("rdy0_sel", {7'h00, SEL}, 8'h01);
        step(1);
        chk("idle_sel", {7'h00, SEL}, 8'h00);
        bus(reg_addr(OFS_ENABLE), 1'b0, 8'h00, 1'b0);
        chk("rdy0_sel_lo", {7'h00, SEL}, 8'h00);
        chk("rdy0_dat_lo", DAT, 8'h81);

        // NMI
        NMI_IN = 1'b1;
        step(2);
        chk("nmi_e2", {7'h00, NMI}, 8'h00);
        step(1);
        chk("nmi_e3", {7'h00, NMI}, 8'h01);
        bus(NMIV, 1'b0, 8'h00, 1'b0);
        chk("nmi_ack_rdy0", {7'h00, NMI}, 8'h01);
        bus(NMIV, 1'b0, 8'h00, 1'b1);
        chk("nmi_ack", {7'h00, NMI}, 8'h00);

        // Asynchronous reset with IRQ and NMI both active
        SRC = 8'h01;
        bus(reg_addr(OFS_ENABLE), 1'b1, 8'h01, 1'b1);
        NMI_IN = 1'b0;
        step(3);
        NMI_IN = 1'b1;
        step(3);
        chk("pre_rst_irq", {7'h00, IRQ}, 8'h01);
        chk("pre_rst_nmi", {7'h00, NMI}, 8'h01);
        SRC = 8'h00;
        #2 RST_N = 1'b0;
        #1;
        chk("arst_irq", {7'h00, IRQ}, 8'h00);
        chk("arst_nmi", {7'h00, NMI}, 8'h00);
        step(2);
        RST_N = 1'b1;
        step(6);
        chk("nmi_held_rst", {7'h00, NMI}, 8'h00);
        bus(reg_addr(OFS_STATUS), 1'b0, 8'h00, 1'b1);
        chk("post_status", DAT, 8'h00);
        bus(reg_addr(OFS_ENABLE), 1'b0, 8'h00, 1'b1);
        chk("post_enable", DAT, 8'h00);
        bus(reg_addr(OFS_EDGE), 1'b0, 8'h00, 1'b1);
        chk("post_edge", DAT, 8'h00);
        bus(reg_addr(OFS_VECTOR), 1'b0, 8'h00, 1'b1);
        chk("post_vector", DAT, 8'h80);
        NMI_IN = 1'b0;
        step(3);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) AD = reg_addr(2'(r));
            else if (r < 6) AD = NMIV;
            else AD = 16'($urandom);
            WE  = ($urandom_range(0, 3) == 0);
            DO  = 8'($urandom);
            RDY = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) SRC = SRC ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) NMI_IN = ~NMI_IN;
            if ($urandom_range(0, 799) == 0) begin
                #2 RST_N = 1'b0;
                #1;
                chk("rnd_arst_irq", {7'h00, IRQ}, 8'h00);
                chk("rnd_arst_nmi", {7'h00, NMI}, 8'h00);
                #1 RST_N = 1'b1;
            end
            @(negedge clk);
        end

        AD = 16'h0000; WE = 1'b0; RDY = 1'b1;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
